// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial adder sequencer driving an external 1-bit full-adder cell
// Feeds one LSB-first bit pair per clock and assembles the WIDTH-bit sum and final carry.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_co,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic             carry;
  logic [CW-1:0]    cnt;

  // busy is a flop that is high exactly in RUN, so the cell only ever sees flop outputs
  assign fa_a   = busy & sa[0];
  assign fa_b   = busy & sb[0];
  assign fa_cin = busy & carry;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            sa    <= a;
            sb    <= b;
            carry <= cin;
            cnt   <= '0;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          sa    <= sa >> 1;
          sb    <= sb >> 1;
          sum   <= {fa_sum, sum[WIDTH-1:1]};
          carry <= fa_co;
          if (cnt == LAST) begin
            cout  <= fa_co;
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - directed and random checks of serial_add_ctrl with an ideal full-adder cell
module tb_serial_add_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       fa_a;
  logic       fa_b;
  logic       fa_cin;
  logic       fa_sum;
  logic       fa_co;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;

  int checks;
  int failures;

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .cin    (cin),
    .fa_a   (fa_a),
    .fa_b   (fa_b),
    .fa_cin (fa_cin),
    .fa_sum (fa_sum),
    .fa_co  (fa_co),
    .busy   (busy),
    .done   (done),
    .sum    (sum),
    .cout   (cout)
  );

  assign fa_sum = fa_a ^ fa_b ^ fa_cin;
  assign fa_co  = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called #1 after an edge with the DUT idle; returns once the DUT is idle again.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                        output int nbusy, output logic saw_done, output int chain_err);
    logic prev_co;
    start = 1'b1; a = ta; b = tb; cin = tc;
    @(posedge clk); #1;
    start = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0;
    nbusy = 0;
    chain_err = 0;
    prev_co = tc;
    while (busy && nbusy < 20) begin
      if (fa_cin !== prev_co) chain_err++;
      prev_co = fa_co;
      nbusy++;
      @(posedge clk); #1;
    end
    saw_done = done;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, fa_a, fa_b, fa_cin, cout, sum} !== 14'd0) begin
      failures++;
      $display("FAIL reset_outputs got busy=%b done=%b fa=%b%b%b cout=%b sum=%h want all zero",
               busy, done, fa_a, fa_b, fa_cin, cout, sum);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int nbusy; logic sd; int ce;
    run_op(8'h0F, 8'h01, 1'b0, nbusy, sd, ce);
    checks++;
    if (nbusy !== 8) begin failures++; $display("FAIL basic_busy_cycles got %0d want 8", nbusy); end
    checks++;
    if (sd !== 1'b1) begin failures++; $display("FAIL basic_done got %b want 1", sd); end
    checks++;
    if ({cout, sum} !== 9'h010) begin failures++; $display("FAIL basic_result got %h want 010", {cout, sum}); end
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL basic_done_one_cycle got %b want 0", done); end
    checks++;
    if ({fa_a, fa_b, fa_cin} !== 3'b000) begin
      failures++; $display("FAIL idle_fa_zero got %b want 000", {fa_a, fa_b, fa_cin});
    end
  endtask

  task automatic test_carry();
    int nbusy; logic sd; int ce;
    run_op(8'hFF, 8'h01, 1'b0, nbusy, sd, ce);
    checks++;
    if ({cout, sum} !== 9'h100 || sd !== 1'b1) begin
      failures++; $display("FAIL carry_ff_01 got %h done=%b want 100 done=1", {cout, sum}, sd);
    end
    run_op(8'hFF, 8'hFF, 1'b1, nbusy, sd, ce);
    checks++;
    if ({cout, sum} !== 9'h1FF || sd !== 1'b1) begin
      failures++; $display("FAIL carry_ff_ff_1 got %h done=%b want 1ff done=1", {cout, sum}, sd);
    end
  endtask

  task automatic test_start_while_busy();
    int dones; int cyc;
    start = 1'b1; a = 8'h12; b = 8'h34; cin = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; a = 8'h00; b = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1; a = 8'hAA; b = 8'hAA; cin = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0;
    dones = 0;
    for (cyc = 0; cyc < 20; cyc++) begin
      if (done) begin
        dones++;
        checks++;
        if ({cout, sum} !== 9'h046) begin
          failures++; $display("FAIL ignored_start_result got %h want 046", {cout, sum});
        end
      end
      @(posedge clk); #1;
    end
    checks++;
    if (dones !== 1) begin failures++; $display("FAIL ignored_start_done_count got %0d want 1", dones); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL ignored_start_busy_after got %b want 0", busy); end
  endtask

  task automatic test_reset_mid_run();
    int dones; int nbusy; logic sd; int ce;
    start = 1'b1; a = 8'h80; b = 8'h80; cin = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; a = 8'h00; b = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, cout, sum, fa_a, fa_b, fa_cin} !== 14'd0) begin
      failures++;
      $display("FAIL async_reset got busy=%b done=%b cout=%b sum=%h fa=%b%b%b want all zero",
               busy, done, cout, sum, fa_a, fa_b, fa_cin);
    end
    #1;
    rst = 1'b0;
    dones = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    checks++;
    if (dones !== 0) begin failures++; $display("FAIL reset_no_done got %0d dones want 0", dones); end
    run_op(8'h01, 8'h02, 1'b0, nbusy, sd, ce);
    checks++;
    if ({cout, sum} !== 9'h003 || sd !== 1'b1) begin
      failures++; $display("FAIL after_reset_op got %h done=%b want 003 done=1", {cout, sum}, sd);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] va [4];
    logic [7:0] vb [4];
    logic [8:0] ve [4];
    int k; int cyc; int last;
    va[0] = 8'h01; vb[0] = 8'h01; ve[0] = 9'h002;
    va[1] = 8'h7F; vb[1] = 8'h01; ve[1] = 9'h080;
    va[2] = 8'hF0; vb[2] = 8'h0F; ve[2] = 9'h0FF;
    va[3] = 8'hC0; vb[3] = 8'h80; ve[3] = 9'h140;
    start = 1'b1; a = va[0]; b = vb[0]; cin = 1'b0;
    k = 0; cyc = 0; last = 0;
    while (k < 4 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (done) begin
        checks++;
        if ({cout, sum} !== ve[k]) begin
          failures++; $display("FAIL b2b_result_%0d got %h want %h", k, {cout, sum}, ve[k]);
        end
        if (k > 0) begin
          checks++;
          if (cyc - last !== 9) begin
            failures++; $display("FAIL b2b_interval_%0d got %0d want 9", k, cyc - last);
          end
        end
        last = cyc;
        k++;
        if (k < 4) begin a = va[k]; b = vb[k]; end
      end
    end
    start = 1'b0; a = 8'h00; b = 8'h00;
    checks++;
    if (k !== 4) begin failures++; $display("FAIL b2b_done_count got %0d want 4", k); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int nbusy; logic sd; int ce;
    int bad_res; int bad_chain; int bad_done;
    logic [7:0] ra; logic [7:0] rb; logic rc; logic [8:0] exp_v;
    bad_res = 0; bad_chain = 0; bad_done = 0;
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      exp_v = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
      run_op(ra, rb, rc, nbusy, sd, ce);
      if ({cout, sum} !== exp_v) begin
        if (bad_res < 5) $display("FAIL random_result a=%h b=%h cin=%b got %h want %h", ra, rb, rc, {cout, sum}, exp_v);
        bad_res++;
      end
      if (ce != 0) bad_chain++;
      if (sd !== 1'b1 || nbusy != 8) bad_done++;
    end
    checks++;
    if (bad_res !== 0) begin failures++; $display("FAIL random_results got %0d bad want 0", bad_res); end
    checks++;
    if (bad_chain !== 0) begin failures++; $display("FAIL random_carry_chain got %0d bad want 0", bad_chain); end
    checks++;
    if (bad_done !== 0) begin failures++; $display("FAIL random_timing got %0d bad want 0", bad_done); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_carry();
    test_start_while_busy();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
